// File: rtl/ddl_pkg.sv
// rtl/ddl_pkg.sv - shared constants, types and lane direction helper for the ramp checker
package ddl_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 16;
  localparam int DOWN_FIRST = 8;

  localparam bit LANE_INC = 1'b1;
  localparam bit LANE_DEC = 1'b0;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } chk_state_t;

  typedef logic [LANE_W-1:0] lane_t;

  // Lanes below the split count up, the rest count down.
  function automatic bit lane_dir(input int i, input int down_first = DOWN_FIRST);
    return (i < down_first) ? LANE_INC : LANE_DEC;
  endfunction

endpackage

// File: rtl/ddl_lane_cmp.sv
// rtl/ddl_lane_cmp.sv - per-lane expected-value register with seed/flywheel select and compare
module ddl_lane_cmp
  import ddl_pkg::*;
#(
  parameter int W   = LANE_W,
  parameter bit INC = LANE_INC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         seed,
  input  logic [W-1:0] data,
  output logic         mismatch
);

  logic [W-1:0] expected;
  logic [W-1:0] base;

  // Seeding follows the received data; flywheeling ignores it so one bad beat costs one error.
  assign base     = seed ? data : expected;
  assign mismatch = (data != expected);

  // Expected value register, advanced once per accepted beat, wrapping modulo 2^W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected <= '0;
    end else if (clear) begin
      expected <= '0;
    end else if (load) begin
      expected <= INC ? (base + W'(1)) : (base - W'(1));
    end
  end

endmodule

// File: rtl/ddl_ramp_checker.sv
// rtl/ddl_ramp_checker.sv - stream sink that locks onto per-lane ramps and counts mismatches
module ddl_ramp_checker
  import ddl_pkg::*;
#(
  parameter int         LANES      = ddl_pkg::LANES,
  parameter int         LANE_W     = ddl_pkg::LANE_W,
  parameter int         DOWN_FIRST = ddl_pkg::DOWN_FIRST,
  parameter int         LOCK_BEATS = 4,
  parameter int         LOSS_ERRS  = 3,
  parameter logic [7:0] READY_MASK = 8'hFF,
  parameter int         CNT_W      = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [LANES*LANE_W-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      enable,
  input  logic                      clear,
  output logic                      locked,
  output logic                      err_flag,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          beat_count,
  output logic [$clog2(LANES)-1:0]  first_err_lane
);

  localparam int IDX_W = $clog2(LANES);
  localparam int RUN_W = 8;

  chk_state_t       state;
  chk_state_t       state_next;
  logic [2:0]       phase;
  logic             tready_q;
  logic             seeded;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;
  logic [LANES-1:0] mismatch;
  logic [IDX_W-1:0] low_lane;
  logic             accept;
  logic             bad;
  logic             lose;
  logic             gain;
  logic             seed;

  assign s_axis_tready = tready_q;
  assign accept        = s_axis_tvalid & tready_q;
  assign bad           = |mismatch;
  assign lose          = (state == LOCKED) & bad & (bad_run == RUN_W'(LOSS_ERRS - 1));
  assign gain          = (state == ACQUIRE) & seeded & ~bad & (good_run == RUN_W'(LOCK_BEATS - 1));
  assign seed          = (state == ACQUIRE) | lose;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      ddl_lane_cmp #(
        .W   (LANE_W),
        .INC (lane_dir(gi, DOWN_FIRST))
      ) u_lane (
        .clk      (aclk),
        .rst      (areset),
        .clear    (clear),
        .load     (accept),
        .seed     (seed),
        .data     (s_axis_tdata[gi*LANE_W +: LANE_W]),
        .mismatch (mismatch[gi])
      );
    end
  endgenerate

  // Rotating backpressure pattern; tready is registered so it trails enable by one cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase    <= 3'd0;
      tready_q <= 1'b0;
    end else begin
      tready_q <= enable & READY_MASK[phase];
      if (enable) begin
        phase <= phase + 3'd1;
      end
    end
  end

  // Lowest mismatching lane index.
  always_comb begin
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        low_lane = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ACQUIRE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: clear wins over any beat in the same cycle.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACQUIRE;
    end else if (accept) begin
      case (state)
        ACQUIRE: if (gain) state_next = LOCKED;
        LOCKED:  if (lose) state_next = ACQUIRE;
        default: state_next = ACQUIRE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Run counters, saturating statistics and first-error capture, updated on accepted beats only.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      seeded         <= 1'b0;
      good_run       <= '0;
      bad_run        <= '0;
      err_flag       <= 1'b0;
      err_count      <= '0;
      beat_count     <= '0;
      first_err_lane <= '0;
    end else if (clear) begin
      seeded         <= 1'b0;
      good_run       <= '0;
      bad_run        <= '0;
      err_flag       <= 1'b0;
      err_count      <= '0;
      beat_count     <= '0;
      first_err_lane <= '0;
    end else if (accept) begin
      if (beat_count != '1) begin
        beat_count <= beat_count + CNT_W'(1);
      end
      if (state == ACQUIRE) begin
        seeded  <= 1'b1;
        bad_run <= '0;
        if (!seeded || bad || gain) begin
          good_run <= '0;
        end else begin
          good_run <= good_run + RUN_W'(1);
        end
      end else begin
        good_run <= '0;
        if (bad) begin
          if (err_count != '1) begin
            err_count <= err_count + CNT_W'(1);
          end
          if (!err_flag) begin
            first_err_lane <= low_lane;
          end
          err_flag <= 1'b1;
          bad_run  <= lose ? '0 : (bad_run + RUN_W'(1));
        end else begin
          bad_run <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddl_ramp_checker.sv
// tb/tb_ddl_ramp_checker.sv - randomized self-checking bench for ddl_ramp_checker
module tb_ddl_ramp_checker;
  import ddl_pkg::*;

  localparam int         NL     = 16;
  localparam int         DW     = 256;
  localparam int         CW     = 32;
  localparam logic [7:0] MASK_B = 8'b1010_0101;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata, tdata_b;
  logic          tvalid, tvalid_b, enable, clear;
  logic          tready, locked, err_flag;
  logic [CW-1:0] err_count, beat_count;
  logic [3:0]    first_err_lane;
  logic          tready_b, locked_b, err_flag_b;
  logic [CW-1:0] err_count_b, beat_count_b;
  logic [3:0]    first_err_lane_b;

  int checks = 0;
  int errors = 0;

  lane_t m_exp[NL];
  bit    m_seeded, m_locked, m_flag;
  int    m_good, m_bad, m_errs, m_beats, m_first;

  int         ph = 0;
  bit         hs, hs_b, exp_tready_b;
  logic [7:0] mask_b_v = MASK_B;
  int         k_a, up_a, dn_a;
  bit         ok;

  always #5 clk = ~clk;

  ddl_ramp_checker #(.READY_MASK(8'hFF)) dut (
    .aclk(clk), .areset(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .enable(enable), .clear(clear), .locked(locked),
    .err_flag(err_flag), .err_count(err_count), .beat_count(beat_count),
    .first_err_lane(first_err_lane)
  );

  ddl_ramp_checker #(.READY_MASK(MASK_B)) dut_b (
    .aclk(clk), .areset(rst), .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b),
    .s_axis_tready(tready_b), .enable(enable), .clear(clear), .locked(locked_b),
    .err_flag(err_flag_b), .err_count(err_count_b), .beat_count(beat_count_b),
    .first_err_lane(first_err_lane_b)
  );

  function automatic lane_t next_val(input int i, input lane_t v);
    return (i < 8) ? lane_t'(v + 16'd1) : lane_t'(v - 16'd1);
  endfunction

  function automatic logic [DW-1:0] ramp(input int k, input int up, input int dn);
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) begin
      if (i < 8) d[i*16 +: 16] = lane_t'(i + up + k);
      else       d[i*16 +: 16] = lane_t'((i - 8) + dn - k);
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_exp[i] = '0;
    m_seeded = 0; m_locked = 0; m_flag = 0;
    m_good = 0; m_bad = 0; m_errs = 0; m_beats = 0; m_first = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d);
    lane_t v[NL];
    int    first_bad;
    first_bad = -1;
    m_beats++;
    for (int i = 0; i < NL; i++) begin
      v[i] = d[i*16 +: 16];
      if (v[i] != m_exp[i] && first_bad < 0) first_bad = i;
    end
    if (!m_locked) begin
      if (m_seeded) m_good = (first_bad < 0) ? m_good + 1 : 0;
      m_seeded = 1;
      for (int i = 0; i < NL; i++) m_exp[i] = next_val(i, v[i]);
      if (m_good == 4) begin
        m_locked = 1; m_good = 0; m_bad = 0;
      end
    end else begin
      if (first_bad >= 0) begin
        m_errs++;
        if (!m_flag) m_first = first_bad;
        m_flag = 1;
        m_bad++;
      end else begin
        m_bad = 0;
      end
      if (m_bad == 3) begin
        m_locked = 0; m_good = 0; m_bad = 0;
        for (int i = 0; i < NL; i++) m_exp[i] = next_val(i, v[i]);
      end else begin
        for (int i = 0; i < NL; i++) m_exp[i] = next_val(i, m_exp[i]);
      end
    end
  endtask

  task automatic tick();
    hs           = tvalid & tready;
    hs_b         = tvalid_b & tready_b;
    exp_tready_b = enable & mask_b_v[ph % 8];
    if (enable) ph++;
    @(posedge clk);
    #1;
    if (clear)   model_reset();
    else if (hs) model_beat(tdata);
  endtask

  task automatic feed(input int n, output bit done);
    int got, cyc;
    got = 0; cyc = 0;
    tvalid = 1;
    while (got < n && cyc < 8 * n + 16) begin
      tdata = ramp(k_a, up_a, dn_a);
      tick();
      cyc++;
      if (hs) begin got++; k_a++; end
    end
    tvalid = 0;
    done = (got == n);
  endtask

  task automatic do_clear();
    tvalid = 0; tvalid_b = 0; clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; clear = 0; tvalid = 0; tvalid_b = 0; tdata = '0; tdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tready !== 1'b0)      begin errors++; $display("FAIL rst_tready got %0d want 0", tready); end
    checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL rst_locked got %0d want 0", locked); end
    checks++; if (err_flag !== 1'b0)    begin errors++; $display("FAIL rst_err_flag got %0d want 0", err_flag); end
    checks++; if (err_count !== '0)     begin errors++; $display("FAIL rst_err_count got %0d want 0", err_count); end
    checks++; if (beat_count !== '0)    begin errors++; $display("FAIL rst_beat_count got %0d want 0", beat_count); end
    checks++; if (first_err_lane !== 4'd0) begin errors++; $display("FAIL rst_first_lane got %0d want 0", first_err_lane); end
    rst = 0; ph = 0;
    model_reset();
  endtask

  task automatic test_lock_count();
    enable = 1;
    tick(); tick();
    k_a = 0; up_a = 0; dn_a = 0;
    feed(4, ok);
    checks++; if (!ok || locked !== 1'b0) begin errors++; $display("FAIL lock_beat4 got %0d want 0", locked); end
    feed(1, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL lock_beat5 got %0d want 1", locked); end
    feed(95, ok);
    checks++; if (!ok || beat_count !== 32'd100) begin errors++; $display("FAIL lock_beat_count got %0d want 100", beat_count); end
    checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL lock_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_single_corrupt();
    tvalid = 1;
    for (int j = 0; j < 6; j++) begin
      tdata = ramp(k_a, up_a, dn_a);
      if (j == 2) tdata[3*16 +: 16] = tdata[3*16 +: 16] ^ 16'h0100;
      tick();
      if (hs) k_a++;
    end
    tvalid = 0;
    checks++; if (err_count !== 32'd1)     begin errors++; $display("FAIL corrupt_err_count got %0d want 1", err_count); end
    checks++; if (err_flag !== 1'b1)       begin errors++; $display("FAIL corrupt_err_flag got %0d want 1", err_flag); end
    checks++; if (first_err_lane !== 4'd3) begin errors++; $display("FAIL corrupt_first_lane got %0d want 3", first_err_lane); end
    checks++; if (locked !== 1'b1)         begin errors++; $display("FAIL corrupt_locked got %0d want 1", locked); end
  endtask

  task automatic test_relock();
    do_clear();
    k_a = 0; up_a = 16'h1000; dn_a = 16'h1000;
    feed(5, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL relock_initial got %0d want 1", locked); end
    k_a = 0; up_a = 0; dn_a = 0;
    feed(2, ok);
    checks++; if (!ok || locked !== 1'b1 || err_count !== 32'd2) begin errors++; $display("FAIL relock_two_errs locked %0d errs %0d want 1 2", locked, err_count); end
    feed(1, ok);
    checks++; if (!ok || locked !== 1'b0 || err_count !== 32'd3) begin errors++; $display("FAIL relock_loss locked %0d errs %0d want 0 3", locked, err_count); end
    feed(3, ok);
    checks++; if (!ok || locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0d want 0", locked); end
    feed(1, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL relock_relocked got %0d want 1", locked); end
    checks++; if (err_count !== 32'd3 || first_err_lane !== 4'd0) begin errors++; $display("FAIL relock_counts errs %0d lane %0d want 3 0", err_count, first_err_lane); end
  endtask

  task automatic test_wrap();
    do_clear();
    k_a = 0; up_a = 16'hFFFF - 6; dn_a = 6;
    feed(6, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %0d want 1", locked); end
    feed(4, ok);
    checks++; if (!ok || err_count !== 32'd0 || err_flag !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_crossing errs %0d flag %0d locked %0d want 0 0 1", err_count, err_flag, locked); end
  endtask

  task automatic test_backpressure();
    int kb;
    do_clear();
    kb = 0;
    tvalid_b = 1;
    for (int c = 0; c < 80; c++) begin
      tdata_b = ramp(kb, 16'h2000, 16'h2000);
      tick();
      if (hs_b) kb++;
      checks++;
      if (tready_b !== exp_tready_b) begin errors++; $display("FAIL bp_tready cycle %0d got %0d want %0d", c, tready_b, exp_tready_b); end
    end
    tvalid_b = 0;
    checks++; if (beat_count_b !== 32'd40) begin errors++; $display("FAIL bp_beat_count got %0d want 40", beat_count_b); end
    checks++; if (err_count_b !== 32'd0 || err_flag_b !== 1'b0 || locked_b !== 1'b1) begin errors++; $display("FAIL bp_state errs %0d flag %0d locked %0d want 0 0 1", err_count_b, err_flag_b, locked_b); end
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    k_a = 0; up_a = 16'h0300; dn_a = 16'h0300;
    feed(6, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL clr_pre_locked got %0d want 1", locked); end
    tdata = ramp(k_a, up_a, dn_a);
    tdata[5*16 +: 16] = ~tdata[5*16 +: 16];
    tvalid = 1; clear = 1;
    tick();
    clear = 0; tvalid = 0;
    checks++; if (err_count !== '0 || err_flag !== 1'b0 || locked !== 1'b0 || beat_count !== '0) begin errors++; $display("FAIL clr_priority errs %0d flag %0d locked %0d beats %0d want 0 0 0 0", err_count, err_flag, locked, beat_count); end
    k_a = 0;
    feed(6, ok);
    tdata = ramp(k_a, up_a, dn_a) ^ 256'h1;
    tvalid = 1;
    tick();
    checks++; if (err_count !== 32'd1 || locked !== 1'b1) begin errors++; $display("FAIL areset_pre errs %0d locked %0d want 1 1", err_count, locked); end
    #3;
    rst = 1;
    #1;
    checks++; if (tready !== 1'b0 || locked !== 1'b0 || err_flag !== 1'b0 || err_count !== '0 || beat_count !== '0 || first_err_lane !== 4'd0)
      begin errors++; $display("FAIL areset_outputs tready %0d locked %0d flag %0d errs %0d beats %0d lane %0d want all 0", tready, locked, err_flag, err_count, beat_count, first_err_lane); end
    tvalid = 0;
    @(posedge clk);
    #1;
    rst = 0; ph = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int            ln;
    k_a = 0; up_a = $urandom_range(0, 65535); dn_a = $urandom_range(0, 65535);
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      tvalid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        up_a = $urandom_range(0, 65535); dn_a = $urandom_range(0, 65535); k_a = 0;
      end
      d = ramp(k_a, up_a, dn_a);
      if ($urandom_range(0, 9) == 0) begin
        ln = $urandom_range(0, NL - 1);
        d[ln*16 +: 16] = d[ln*16 +: 16] ^ lane_t'($urandom_range(1, 65535));
      end
      tdata = d;
      tick();
      if (hs) k_a++;
      checks++;
      if (locked !== m_locked || err_flag !== m_flag || err_count !== CW'(m_errs) ||
          beat_count !== CW'(m_beats) || first_err_lane !== 4'(m_first)) begin
        errors++;
        $display("FAIL rand cycle %0d got lk %0d fl %0d er %0d bt %0d ln %0d want %0d %0d %0d %0d %0d",
                 c, locked, err_flag, err_count, beat_count, first_err_lane,
                 m_locked, m_flag, m_errs, m_beats, m_first);
      end
    end
    tvalid = 0; enable = 1;
  endtask

  initial begin
    test_reset();
    test_lock_count();
    test_single_corrupt();
    test_relock();
    test_wrap();
    test_backpressure();
    test_clear_and_reset();
    enable = 1;
    tick();
    do_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
